// File: rtl/pwm_duty_capture_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM capture block and its generator partner:
// capture FSM state encoding, the full-scale duty value and the board clock /
// PWM rate constants. No ports.
// ---------------------------------------------------------------------------
package pwm_pkg;

    typedef enum logic [1:0] {
        S_ARM   = 2'd0,
        S_MEAS  = 2'd1,
        S_STUCK = 2'd2
    } state_t;

    // Duty full scale, identical to the generator's input range
    localparam int unsigned DUTY_MAX = 255;

    // 50 MHz system clock, 100 Hz PWM
    localparam int unsigned CLK_HZ         = 50_000_000;
    localparam int unsigned PWM_HZ         = 100;
    localparam int unsigned PWM_PERIOD_CYC = CLK_HZ / PWM_HZ;
    localparam int unsigned STUCK_TIMEOUT  = 2 * PWM_PERIOD_CYC;

    // Quotient bits produced by the duty divider, one per clock
    localparam int unsigned DIV_STEPS = 8;

endpackage

// File: rtl/pwm_duty_div.sv
// ---------------------------------------------------------------------------
// pwm_duty_div
// Restoring divider that turns a high-time / period pair into an 8-bit duty:
//   duty = floor((H*255 + floor(P/2)) / P)
// One quotient bit per clock, MSB first, 8 cycles per result.
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_start               launch a division (ignored while busy)
//   i_abort               drop any division in flight
//   i_high, i_period      H and P operands, sampled on i_start
//   o_busy                division in progress
//   o_done                last iteration cycle; o_quot is the final quotient
//   o_quot                quotient (meaningful while o_done is high)
// ---------------------------------------------------------------------------
module pwm_duty_div
    import pwm_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_high,
    input  logic [CNT_W-1:0] i_period,
    output logic             o_busy,
    output logic             o_done,
    output logic [7:0]       o_quot
);

    localparam int         NUM_W     = CNT_W + 8;
    localparam logic [2:0] LAST_STEP = 3'(DIV_STEPS - 1);

    logic             r_busy;
    logic [2:0]       r_step;
    logic [NUM_W-1:0] r_rem;
    logic [NUM_W-1:0] r_div;
    logic [7:0]       r_quot;

    logic [NUM_W-1:0] w_trial;
    logic             w_take;
    logic [7:0]       w_quot_next;
    logic             w_launch;

    // H*255 is formed as H*256 - H; adding P/2 makes the floor divide round
    function automatic logic [NUM_W-1:0] duty_numerator(
        input logic [CNT_W-1:0] h,
        input logic [CNT_W-1:0] p
    );
        logic [NUM_W-1:0] h_x256;
        logic [NUM_W-1:0] h_x1;
        logic [NUM_W-1:0] half_p;
        h_x256 = {h, 8'd0};
        h_x1   = {8'd0, h};
        half_p = {9'd0, p[CNT_W-1:1]};
        return h_x256 - h_x1 + half_p;
    endfunction

    assign w_launch    = i_start && !r_busy;
    assign w_trial     = r_div << r_step;
    assign w_take      = (r_rem >= w_trial);
    assign w_quot_next = r_quot | ({7'd0, w_take} << r_step);

    // Control: idle -> busy for exactly DIV_STEPS cycles
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy <= 1'b0;
            r_step <= 3'd0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
        end else if (w_launch) begin
            r_busy <= 1'b1;
            r_step <= LAST_STEP;
        end else if (r_busy) begin
            r_step <= r_step - 3'd1;
            if (r_step == 3'd0) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Datapath: remainder and partial quotient
    always_ff @(posedge i_clk) begin
        if (w_launch) begin
            r_rem  <= duty_numerator(i_high, i_period);
            r_div  <= {8'd0, i_period};
            r_quot <= 8'd0;
        end else if (r_busy) begin
            if (w_take) begin
                r_rem <= r_rem - w_trial;
            end
            r_quot <= w_quot_next;
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_step == 3'd0) && !i_abort;
    assign o_quot = w_quot_next;

endmodule

// File: rtl/pwm_duty_capture.sv
// ---------------------------------------------------------------------------
// pwm_duty_capture
// Measures an asynchronous PWM input: period P and high time H in clock
// cycles (rising edge to rising edge) and the 8-bit duty on the 0..255 scale.
// A line with no rising edge for TIMEOUT cycles is reported as stuck.
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_pwm_in         asynchronous PWM input
//   o_duty_cycle     last measured duty (0..255)
//   o_period         last measured period, clk cycles
//   o_high_time      last measured high time, clk cycles
//   o_valid          one-cycle pulse when the three outputs update
//   o_stuck          level, no rising edge for TIMEOUT cycles
//   o_overrun        one-cycle pulse, a period was dropped (divider busy)
// ---------------------------------------------------------------------------
module pwm_duty_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pwm_in,
    output logic [7:0]       o_duty_cycle,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high_time,
    output logic             o_valid,
    output logic             o_stuck,
    output logic             o_overrun
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    state_t           r_state;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_snap_p;
    logic [CNT_W-1:0] r_snap_h;
    logic [7:0]       r_duty;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_valid;
    logic             r_stuck;
    logic             r_overrun;

    logic             w_rise;
    logic             w_fall;
    logic             w_timeout;
    logic             w_start;
    logic             w_abort;
    logic             w_div_busy;
    logic             w_div_done;
    logic [7:0]       w_div_quot;

    // Input synchronizer and edge history
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_pwm_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rise    = r_sync2 && !r_prev;
    assign w_fall    = !r_sync2 && r_prev;
    assign w_timeout = (r_pcnt == CNT_TO);

    // A rise always beats a timeout in the same cycle
    assign w_start = (r_state == S_MEAS) && w_rise && !w_div_busy;
    assign w_abort = (r_state != S_STUCK) && !w_rise && w_timeout;

    pwm_duty_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (w_start),
        .i_abort  (w_abort),
        .i_high   (r_hcnt),
        .i_period (r_pcnt),
        .o_busy   (w_div_busy),
        .o_done   (w_div_done),
        .o_quot   (w_div_quot)
    );

    // P/H held here while the divider works so all three outputs move together
    always_ff @(posedge i_clk) begin
        if (w_start) begin
            r_snap_p <= r_pcnt;
            r_snap_h <= r_hcnt;
        end
    end

    // FSM, counters and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_ARM;
            r_pcnt    <= '0;
            r_hcnt    <= '0;
            r_duty    <= 8'd0;
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_stuck   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;

            if (w_div_done) begin
                r_duty   <= w_div_quot;
                r_period <= r_snap_p;
                r_high   <= r_snap_h;
                r_valid  <= 1'b1;
            end

            case (r_state)
                S_ARM: begin
                    if (w_rise) begin
                        r_state <= S_MEAS;
                        r_pcnt  <= CNT_ONE;
                        r_hcnt  <= CNT_ONE;
                    end else if (w_timeout) begin
                        r_state  <= S_STUCK;
                        r_stuck  <= 1'b1;
                        r_valid  <= 1'b1;
                        r_duty   <= r_sync2 ? 8'(DUTY_MAX) : 8'd0;
                        r_period <= '0;
                        r_high   <= '0;
                    end else begin
                        r_pcnt <= r_pcnt + CNT_ONE;
                    end
                end
                S_MEAS: begin
                    if (w_rise) begin
                        // Counters restart even when the snapshot is dropped
                        r_pcnt <= CNT_ONE;
                        r_hcnt <= CNT_ONE;
                        if (w_div_busy) begin
                            r_overrun <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state  <= S_STUCK;
                        r_stuck  <= 1'b1;
                        r_valid  <= 1'b1;
                        r_duty   <= r_sync2 ? 8'(DUTY_MAX) : 8'd0;
                        r_period <= '0;
                        r_high   <= '0;
                    end else begin
                        r_pcnt <= r_pcnt + CNT_ONE;
                        r_hcnt <= r_hcnt + {{(CNT_W-1){1'b0}}, r_sync2};
                    end
                end
                S_STUCK: begin
                    // Counters stay frozen until the line moves again
                    if (w_rise) begin
                        r_state <= S_MEAS;
                        r_stuck <= 1'b0;
                        r_pcnt  <= CNT_ONE;
                        r_hcnt  <= CNT_ONE;
                    end else if (w_fall) begin
                        r_state <= S_ARM;
                        r_stuck <= 1'b0;
                        r_pcnt  <= '0;
                        r_hcnt  <= '0;
                    end
                end
                default: begin
                    r_state <= S_ARM;
                    r_pcnt  <= '0;
                    r_hcnt  <= '0;
                end
            endcase
        end
    end

    assign o_duty_cycle = r_duty;
    assign o_period     = r_period;
    assign o_high_time  = r_high;
    assign o_valid      = r_valid;
    assign o_stuck      = r_stuck;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_duty_capture
// Scoreboard bench for pwm_duty_capture with TIMEOUT = 1000. The driver
// pushes the expected result for each completed period (or stuck entry) at
// the moment it drives the edge that produces it; a negedge monitor pops and
// compares whenever the DUT pulses valid or overrun.
// ---------------------------------------------------------------------------
module tb_pwm_duty_capture;

    localparam int CNT_W   = 20;
    localparam int TIMEOUT = 1000;

    // Latencies from the negedge that drives a rise on pwm_in
    localparam int LAT_VALID = 11;            // 2 sync + 9 pipeline
    localparam int LAT_OVR   = 3;
    localparam int LAT_STUCK = 2 + TIMEOUT + 1;
    localparam int DIV_GAP   = 9;

    logic             clk;
    logic             rst_n;
    logic             pwm_in;
    logic [7:0]       duty_cycle;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             stuck;
    logic             overrun;

    pwm_duty_capture #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pwm_in     (pwm_in),
        .o_duty_cycle (duty_cycle),
        .o_period     (period),
        .o_high_time  (high_time),
        .o_valid      (valid),
        .o_stuck      (stuck),
        .o_overrun    (overrun)
    );

    typedef struct {
        int duty;
        int per;
        int high;
        int stk;
        int vcyc;
    } exp_t;

    exp_t exp_q[$];
    int   ovr_q[$];
    exp_t mon_e;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;

    // Driver-side model state
    bit meas_open = 1'b0;
    int prev_h = 0;
    int prev_p = 0;
    int last_rise = 0;
    int last_launch = -100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint obs, input longint expv);
        n_vec++;
        if (obs !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic int duty_model(input int h, input int p);
        return (h * 255 + p / 2) / p;
    endfunction

    task automatic push_exp(input int d, input int p, input int h, input int s, input int vc);
        exp_t e;
        e.duty = d;
        e.per  = p;
        e.high = h;
        e.stk  = s;
        e.vcyc = vc;
        exp_q.push_back(e);
    endtask

    // One PWM period starting with a rise; the rise closes the previous period
    task automatic pulse(input int h, input int l);
        int rc;
        rc = cyc;
        if (meas_open) begin
            if (rc - last_launch >= DIV_GAP) begin
                push_exp(duty_model(prev_h, prev_p), prev_p, prev_h, 0, rc + LAT_VALID);
                last_launch = rc;
            end else begin
                ovr_q.push_back(rc + LAT_OVR);
            end
        end
        meas_open = 1'b1;
        prev_h    = h;
        prev_p    = h + l;
        last_rise = rc;
        pwm_in = 1'b1;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_duty"},    longint'(duty_cycle), 0);
        check({tag, "_period"},  longint'(period),     0);
        check({tag, "_high"},    longint'(high_time),  0);
        check({tag, "_valid"},   longint'(valid),      0);
        check({tag, "_stuck"},   longint'(stuck),      0);
        check({tag, "_overrun"}, longint'(overrun),    0);
    endtask

    // Monitor: compare every valid / overrun pulse against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() > 0 && exp_q[0].vcyc < cyc) begin
                mon_e = exp_q.pop_front();
                check("missing_valid_at", longint'(cyc), longint'(mon_e.vcyc));
            end
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("valid_cycle", longint'(cyc),        longint'(mon_e.vcyc));
                    check("duty",        longint'(duty_cycle), longint'(mon_e.duty));
                    check("period",      longint'(period),     longint'(mon_e.per));
                    check("high_time",   longint'(high_time),  longint'(mon_e.high));
                    check("stuck_at_vld", longint'(stuck),     longint'(mon_e.stk));
                end
            end
            if (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
                check("missing_overrun_at", longint'(cyc), longint'(ovr_q.pop_front()));
            end
            if (overrun) begin
                if (ovr_q.size() == 0) begin
                    check("spurious_overrun", 1, 0);
                end else begin
                    check("overrun_cycle", longint'(cyc), longint'(ovr_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int rc;
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 50 % square wave, P=100 H=50 -> 128 (first period discarded)
        repeat (4) pulse(50, 50);
        // H=1 -> 3, H=99 -> 252
        repeat (3) pulse(1, 99);
        repeat (3) pulse(99, 1);
        // P=5: rises inside the busy window overrun
        repeat (10) pulse(2, 3);
        check("duty_after_overrun", longint'(duty_cycle), 102);
        pulse(50, 50);
        pulse(50, 50);

        // Line held low -> stuck with duty 0
        push_exp(0, 0, 0, 1, last_rise + LAT_STUCK);
        while (cyc < last_rise + LAT_STUCK + 5) @(negedge clk);
        meas_open   = 1'b0;
        last_launch = -100;
        check("stuck_low_level", longint'(stuck), 1);
        check("stuck_low_duty",  longint'(duty_cycle), 0);

        // Rise leaves stuck without a result; held high -> stuck with 255
        rc = cyc;
        pwm_in = 1'b1;
        repeat (4) @(negedge clk);
        check("stuck_clear_rise", longint'(stuck), 0);
        push_exp(255, 0, 0, 1, rc + LAT_STUCK);
        while (cyc < rc + LAT_STUCK + 5) @(negedge clk);
        check("stuck_high_level", longint'(stuck), 1);
        check("stuck_high_duty",  longint'(duty_cycle), 255);
        pwm_in = 1'b0;
        repeat (4) @(negedge clk);
        check("stuck_clear_fall", longint'(stuck), 0);

        // Back through S_ARM: first period discarded
        repeat (3) pulse(50, 50);

        // Reset during the low phase of a period
        pulse(30, 20);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("midreset");
        repeat (30) @(negedge clk);
        meas_open   = 1'b0;
        last_launch = -100;

        // Generator-style full-spread settings scaled to P=510:
        // setting 200 -> H=400, setting 1 -> H=2
        repeat (3) pulse(400, 110);
        repeat (3) pulse(2, 508);
        pulse(50, 50);

        repeat (20) @(negedge clk);
        check("results_drained",  longint'(exp_q.size()), 0);
        check("overruns_drained", longint'(ovr_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
